// File: rtl/multi_task_scheduler_if.sv
// Bundles the per-channel event, configuration and status lines of the task scheduler.
// The master drives events and configuration; the slave (the scheduler) returns task status.
interface multi_task_scheduler_if #(
   parameter int NUM_CH  = 4,
   parameter int TIMER_W = 8
);
   logic [NUM_CH-1:0]         event_in;
   logic [2*NUM_CH-1:0]       cfg_mode;
   logic [NUM_CH*TIMER_W-1:0] cfg_duration;
   logic [NUM_CH-1:0]         cfg_retrigger;
   logic [NUM_CH-1:0]         cancel;
   logic [NUM_CH-1:0]         task_active;
   logic [NUM_CH-1:0]         task_done;
   logic [NUM_CH-1:0]         trig_dropped;

   modport master (
      output event_in, cfg_mode, cfg_duration, cfg_retrigger, cancel,
      input  task_active, task_done, trig_dropped
   );

   modport slave (
      input  event_in, cfg_mode, cfg_duration, cfg_retrigger, cancel,
      output task_active, task_done, trig_dropped
   );
endinterface

// File: rtl/multi_task_scheduler.sv
// Independent per-channel event-triggered task timers: each channel turns an edge or level
// on its event line into a fixed-length active window, with retrigger, drop and cancel handling.
//
// state  | meaning
// idle   | timer == 0, task_active low, a trigger with nonzero duration loads the timer
// active | timer  > 0, counts down; terminal count (timer == 1) ends the task with task_done
module multi_task_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int TIMER_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multi_task_scheduler_if.slave bus
);

   localparam logic [1:0] MODE_RISE  = 2'b00;
   localparam logic [1:0] MODE_FALL  = 2'b01;
   localparam logic [1:0] MODE_LEVEL = 2'b10;
   localparam logic [1:0] MODE_BOTH  = 2'b11;

   logic [TIMER_W-1:0] timer_q [NUM_CH];
   logic [TIMER_W-1:0] timer_d [NUM_CH];
   logic [NUM_CH-1:0]  prev_q;
   logic [NUM_CH-1:0]  active_q, active_d;
   logic [NUM_CH-1:0]  done_q, done_d;
   logic [NUM_CH-1:0]  drop_q, drop_d;
   logic [NUM_CH-1:0]  trig;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         logic [1:0]         mode;
         logic [TIMER_W-1:0] dur;
         mode       = bus.cfg_mode[2*i +: 2];
         dur        = bus.cfg_duration[i*TIMER_W +: TIMER_W];
         timer_d[i] = timer_q[i];
         active_d[i] = active_q[i];
         done_d[i]  = 1'b0;
         drop_d[i]  = 1'b0;

         case (mode)
            MODE_RISE:  trig[i] = bus.event_in[i] & ~prev_q[i];
            MODE_FALL:  trig[i] = ~bus.event_in[i] & prev_q[i];
            MODE_LEVEL: trig[i] = bus.event_in[i];
            MODE_BOTH:  trig[i] = bus.event_in[i] ^ prev_q[i];
            default:    trig[i] = 1'b0;
         endcase

         if (bus.cancel[i]) begin
            timer_d[i]  = '0;
            active_d[i] = 1'b0;
         end else if (timer_q[i] == '0) begin
            if (trig[i] && dur != '0) begin
               timer_d[i]  = dur;
               active_d[i] = 1'b1;
            end
         end else if (trig[i] && bus.cfg_retrigger[i] && dur != '0) begin
            timer_d[i]  = dur;
            active_d[i] = 1'b1;
         end else begin
            // A level trigger while busy is simply re-presented later, so only edges count as dropped.
            drop_d[i]  = trig[i] && (mode != MODE_LEVEL) && !bus.cfg_retrigger[i];
            timer_d[i] = timer_q[i] - 1'b1;
            if (timer_q[i] == TIMER_W'(1)) begin
               active_d[i] = 1'b0;
               done_d[i]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            timer_q[i] <= '0;
         end
         prev_q   <= '0;
         active_q <= '0;
         done_q   <= '0;
         drop_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            timer_q[i] <= timer_d[i];
         end
         prev_q   <= bus.event_in;
         active_q <= active_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.task_active  = active_q;
   assign bus.task_done    = done_q;
   assign bus.trig_dropped = drop_q;

endmodule
